// File: rtl/rom_fetch_sequencer_pkg.sv
// Shared definitions for the ROM fetch sequencer: opcodes, field layout, FSM encoding.
package rom_fetch_sequencer_pkg;

    localparam int unsigned OpcodeW = 4;

    localparam logic [OpcodeW-1:0] OpNop        = 4'h0;
    localparam logic [OpcodeW-1:0] OpBle        = 4'h1;
    localparam logic [OpcodeW-1:0] OpAdd        = 4'h2;
    localparam logic [OpcodeW-1:0] OpSto        = 4'h3;
    localparam logic [OpcodeW-1:0] OpDisplayVga = 4'h4;
    localparam logic [OpcodeW-1:0] OpLed        = 4'h5;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StIssue = 2'd1,
        StDelay = 2'd2
    } state_e;

    function automatic logic is_nop(input logic [OpcodeW-1:0] opcode);
        return opcode == OpNop;
    endfunction

endpackage

// File: rtl/rom_fetch_delay_counter.sv
// NOP stall counter: loads N, counts down to zero, flags the last stall cycle.
// Only present when ROM_FETCH_NOP_DELAY_EN is defined.
`ifdef ROM_FETCH_NOP_DELAY_EN
module rom_fetch_delay_counter #(
    parameter int unsigned DELAY_W = 24
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [DELAY_W-1:0] i_value,
    output logic               o_done
);

    logic [DELAY_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - DELAY_W'(1);
        end
    end

    // Done on the final stall cycle so the FSM leaves DELAY after exactly N cycles.
    assign o_done = (r_count == DELAY_W'(1));

endmodule
`endif

// File: rtl/rom_fetch_sequencer.sv
// Program sequencer: PC, ROM fetch, valid/ready issue to decode, branch redirect.
// ROM_FETCH_NOP_DELAY_EN enables timed NOP stalls (DELAY state, oDelayActive).
module rom_fetch_sequencer
    import rom_fetch_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned INSN_W   = 28,
    parameter int unsigned TARGET_W = 8,
    parameter int unsigned DELAY_W  = 24,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                Clock,
    input  logic                Reset,
    output logic [ADDR_W-1:0]   oAddress,
    input  logic [INSN_W-1:0]   iInstruction,
    output logic [INSN_W-1:0]   oInstruction,
    output logic                oValid,
    input  logic                iReady,
    input  logic                iBranchTaken,
    input  logic [TARGET_W-1:0] iBranchTarget,
    input  logic                iHalt,
    output logic                oDelayActive
);

    state_e              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [INSN_W-1:0]   r_insn;
    logic                r_valid;
    logic                w_accept;
    logic [ADDR_W-1:0]   w_next_pc;

    assign w_accept  = (r_state == StIssue) && iReady;
    assign w_next_pc = iBranchTaken ? {{(ADDR_W-TARGET_W){1'b0}}, iBranchTarget}
                                    : r_pc + ADDR_W'(1);

`ifdef ROM_FETCH_NOP_DELAY_EN
    logic               r_delay_active;
    logic [DELAY_W-1:0] w_imm;
    logic               w_stall;
    logic               w_delay_done;

    assign w_imm   = r_insn[DELAY_W-1:0];
    assign w_stall = is_nop(r_insn[INSN_W-1 -: OpcodeW]) && (w_imm != '0);

    rom_fetch_delay_counter #(
        .DELAY_W (DELAY_W)
    ) u_delay_counter (
        .i_clk   (Clock),
        .i_rst   (Reset),
        .i_load  (w_accept && w_stall),
        .i_value (w_imm),
        .o_done  (w_delay_done)
    );

    assign oDelayActive = r_delay_active;
`else
    assign oDelayActive = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= StFetch;
            r_pc    <= ADDR_W'(RESET_PC);
            r_insn  <= '0;
            r_valid <= 1'b0;
`ifdef ROM_FETCH_NOP_DELAY_EN
            r_delay_active <= 1'b0;
`endif
        end else begin
            case (r_state)
                StFetch: begin
                    if (!iHalt) begin
                        r_insn  <= iInstruction;
                        r_valid <= 1'b1;
                        r_state <= StIssue;
                    end
                end
                StIssue: begin
                    if (w_accept) begin
                        r_valid <= 1'b0;
                        r_pc    <= w_next_pc;
`ifdef ROM_FETCH_NOP_DELAY_EN
                        if (w_stall) begin
                            r_state        <= StDelay;
                            r_delay_active <= 1'b1;
                        end else begin
                            r_state <= StFetch;
                        end
`else
                        r_state <= StFetch;
`endif
                    end
                end
                StDelay: begin
`ifdef ROM_FETCH_NOP_DELAY_EN
                    if (w_delay_done) begin
                        r_state        <= StFetch;
                        r_delay_active <= 1'b0;
                    end
`else
                    r_state <= StFetch;
`endif
                end
                default: r_state <= StFetch;
            endcase
        end
    end

    assign oAddress     = r_pc;
    assign oInstruction = r_insn;
    assign oValid       = r_valid;

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Scoreboard bench for rom_fetch_sequencer; RESET_PC near the top of memory to cover PC wrap.
module tb_rom_fetch_sequencer;
    import rom_fetch_sequencer_pkg::*;

    localparam logic [15:0] ResetPc = 16'hFFFC;
`ifdef ROM_FETCH_NOP_DELAY_EN
    localparam int ExpDelay = 4000;
    localparam logic ExpMidDelay = 1'b1;
`else
    localparam int ExpDelay = 0;
    localparam logic ExpMidDelay = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] addr;
        logic [27:0] word;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] oAddress;
    logic [27:0] iInstruction;
    logic [27:0] oInstruction;
    logic        oValid;
    logic        iReady;
    logic        iBranchTaken;
    logic [7:0]  iBranchTarget;
    logic        iHalt;
    logic        oDelayActive;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    rom_fetch_sequencer #(
        .ADDR_W   (16),
        .INSN_W   (28),
        .TARGET_W (8),
        .DELAY_W  (24),
        .RESET_PC (32'(ResetPc))
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .oAddress      (oAddress),
        .iInstruction  (iInstruction),
        .oInstruction  (oInstruction),
        .oValid        (oValid),
        .iReady        (iReady),
        .iBranchTaken  (iBranchTaken),
        .iBranchTarget (iBranchTarget),
        .iHalt         (iHalt),
        .oDelayActive  (oDelayActive)
    );

    always #5 Clock = ~Clock;

    // Bench-owned program ROM.
    function automatic logic [27:0] rom(input logic [15:0] a);
        case (a)
            16'd4:   return {OpNop, 24'd4000};
            16'd8:   return {OpBle, 24'h000008};
            default: return {OpAdd, 8'h5A, a};
        endcase
    endfunction

    assign iInstruction = rom(oAddress);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_fetch(input logic [15:0] a);
        exp_t e;
        e.addr = a;
        e.word = rom(a);
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted word must be the next expected fetch.
    always @(negedge Clock) begin
        if (!Reset && oValid && iReady) begin
            exp_t e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_accept: got addr %h word %h expected none",
                         oAddress, oInstruction);
            end else begin
                e = exp_q.pop_front();
                if (oAddress !== e.addr || oInstruction !== e.word) begin
                    n_fail++;
                    $display("FAIL accept: got addr %h word %h expected addr %h word %h",
                             oAddress, oInstruction, e.addr, e.word);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        Reset = 1'b1;
        iReady = 1'b0;
        iHalt = 1'b0;
        iBranchTaken = 1'b0;
        iBranchTarget = 8'h00;
        repeat (3) tick();
        check("reset_addr", 32'(oAddress), 32'(ResetPc));
        check("reset_valid", 32'(oValid), 0);
        check("reset_insn", 32'(oInstruction), 0);
        check("reset_delay", 32'(oDelayActive), 0);

        // Free-running fetch across the PC wrap: FFFC..FFFF, 0..3.
        Reset = 1'b0;
        iReady = 1'b1;
        for (int i = 0; i < 8; i++) expect_fetch(ResetPc + 16'(i));
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("valid_pulse", 32'(oValid), 32'(k % 2));
        end
        check("pc_after_wrap", 32'(oAddress), 4);

        // Halt in FETCH holds PC with no valid.
        iReady = 1'b0;
        iHalt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("halt_valid", 32'(oValid), 0);
            check("halt_addr", 32'(oAddress), 4);
        end
        iHalt = 1'b0;
        expect_fetch(16'd4);
        tick();
        check("issue4_valid", 32'(oValid), 1);

        // Stall in ISSUE with branch pulses and halt that must be ignored.
        for (int k = 0; k < 5; k++) begin
            iBranchTaken = (k % 2 == 0);
            iBranchTarget = 8'h77;
            iHalt = (k % 2 == 1);
            tick();
            check("stall_valid", 32'(oValid), 1);
            check("stall_insn", 32'(oInstruction), 32'(rom(16'd4)));
            check("stall_addr", 32'(oAddress), 4);
        end
        iBranchTaken = 1'b0;
        iHalt = 1'b0;
        iReady = 1'b1;
        tick();
        iReady = 1'b0;

        // NOP 4000: stall length, then fetch PC+1.
        cnt = 0;
        while (oDelayActive && cnt < 5000) begin
            cnt++;
            tick();
        end
        check("nop_delay_cycles", 32'(cnt), 32'(ExpDelay));
        tick();
        check("after_nop_valid", 32'(oValid), 1);
        check("after_nop_addr", 32'(oAddress), 5);

        // Branch from 8 to 6; PC 9 must never be fetched.
        expect_fetch(16'd5);
        expect_fetch(16'd6);
        expect_fetch(16'd7);
        expect_fetch(16'd8);
        expect_fetch(16'd6);
        expect_fetch(16'd7);
        iReady = 1'b1;
        iBranchTarget = 8'd6;
        for (int k = 0; k < 12; k++) begin
            iBranchTaken = (oAddress == 16'd8);
            tick();
        end
        check("issue8_addr", 32'(oAddress), 8);
        check("issue8_valid", 32'(oValid), 1);

        // Branch back to the NOP, then reset in the middle of its stall.
        expect_fetch(16'd8);
        iBranchTaken = 1'b1;
        iBranchTarget = 8'd4;
        tick();
        iBranchTaken = 1'b0;
        check("branch_to4_addr", 32'(oAddress), 4);
        expect_fetch(16'd4);
        tick();
        tick();
`ifdef ROM_FETCH_NOP_DELAY_EN
        repeat (2766) tick();
`endif
        check("mid_delay_active", 32'(oDelayActive), 32'(ExpMidDelay));
        check("queue_drained", 32'(exp_q.size()), 0);
        Reset = 1'b1;
        #1;
        check("async_reset_addr", 32'(oAddress), 32'(ResetPc));
        check("async_reset_valid", 32'(oValid), 0);
        check("async_reset_delay", 32'(oDelayActive), 0);
        check("async_reset_insn", 32'(oInstruction), 0);
        tick();
        Reset = 1'b0;
        expect_fetch(ResetPc);
        tick();
        check("post_reset_valid", 32'(oValid), 1);
        check("post_reset_addr", 32'(oAddress), 32'(ResetPc));
        tick();
        iReady = 1'b0;
        tick();
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
